// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map and mstatus field positions for the machine-mode CSR file.
package csr_regfile_pkg;

  localparam int unsigned CSR_ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH     = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // Read-only CSR space is encoded by address bits [11:10] == 2'b11.
  function automatic logic is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_regfile_counter64.sv
// 64-bit free-running counter with independent 32-bit half loads; a load suppresses the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [63:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (we_lo) begin
      count <= {count[63:32], wdata};
    end else if (we_hi) begin
      count <= {wdata, count[31:0]};
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

  assign lo = count[31:0];
  assign hi = count[63:32];

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read port, RMW write port, trap/mret state and counters.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  output logic        illegal_o,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  localparam logic [31:0] ALIGN_MASK = ~32'h3;

  logic        st_mie;
  logic        st_mpie;
  logic [31:0] mie_reg;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mstatus_rd;
  logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic        wr;
  logic        unimpl;

  // Trap and mret both take priority and drop the CSR write in the same cycle.
  assign wr = we_i && !trap_i && !mret_i && !is_read_only(waddr_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_reg  <= '0;
      mtvec    <= MTVEC_RESET & ALIGN_MASK;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (trap_i) begin
      mepc    <= trap_pc_i & ALIGN_MASK;
      mcause  <= trap_cause_i;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_i) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr) begin
      case (waddr_i)
        CSR_MSTATUS: begin
          st_mie  <= wdata_i[MSTATUS_MIE_BIT];
          st_mpie <= wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_reg  <= wdata_i;
        CSR_MTVEC:    mtvec    <= wdata_i & ALIGN_MASK;
        CSR_MSCRATCH: mscratch <= wdata_i;
        CSR_MEPC:     mepc     <= wdata_i & ALIGN_MASK;
        CSR_MCAUSE:   mcause   <= wdata_i;
        default: ;
      endcase
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (wr && waddr_i == CSR_MCYCLE),
    .we_hi (wr && waddr_i == CSR_MCYCLEH),
    .wdata (wdata_i),
    .lo    (cyc_lo),
    .hi    (cyc_hi)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_i),
    .we_lo (wr && waddr_i == CSR_MINSTRET),
    .we_hi (wr && waddr_i == CSR_MINSTRETH),
    .wdata (wdata_i),
    .lo    (ins_lo),
    .hi    (ins_hi)
  );

  always_comb begin
    mstatus_rd                   = 32'h0000_1800;
    mstatus_rd[MSTATUS_MIE_BIT]  = st_mie;
    mstatus_rd[MSTATUS_MPIE_BIT] = st_mpie;
  end

  always_comb begin
    rdata_o = '0;
    unimpl  = 1'b0;
    case (raddr_i)
      CSR_MSTATUS:                 rdata_o = mstatus_rd;
      CSR_MISA:                    rdata_o = MISA_VALUE;
      CSR_MIE:                     rdata_o = mie_reg;
      CSR_MTVEC:                   rdata_o = mtvec;
      CSR_MSCRATCH:                rdata_o = mscratch;
      CSR_MEPC:                    rdata_o = mepc;
      CSR_MCAUSE:                  rdata_o = mcause;
      CSR_MCYCLE,   CSR_CYCLE:     rdata_o = cyc_lo;
      CSR_MCYCLEH,  CSR_CYCLEH:    rdata_o = cyc_hi;
      CSR_MINSTRET, CSR_INSTRET:   rdata_o = ins_lo;
      CSR_MINSTRETH, CSR_INSTRETH: rdata_o = ins_hi;
      CSR_MHARTID:                 rdata_o = HART_ID;
      default:                     unimpl  = 1'b1;
    endcase
  end

  assign illegal_o = unimpl || (we_i && is_read_only(waddr_i));
  assign mtvec_o   = mtvec;
  assign mepc_o    = mepc;
  assign mie_o     = st_mie;

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR storage for the RV32I core. Consumes the write-enable, address and merged write data produced by the CSR read-modify-write logic in the execute stage, and returns the current CSR value to that logic on a combinational read port. Also holds the trap state (mepc, mcause, mstatus.MIE/MPIE), free-running cycle/instret counters, and the trap-entry/mret updates driven by the exception path.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] forced 0
- HART_ID, 0, value returned for mhartid
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- raddr_i  in  `CsrMemAddrWIDTH (12)  CSR read address
- rdata_o  out  `DATA_WIDTH (32)  CSR read data, combinational from raddr_i
- illegal_o  out  1  raddr_i unimplemented, or we_i to a read-only address
- we_i  in  1  CSR write enable
- waddr_i  in  12  CSR write address
- wdata_i  in  32  CSR write data (already merged for rs/rc/w variants)
- instret_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap entry this cycle
- trap_pc_i  in  32  PC of trapping instruction
- trap_cause_i  in  32  mcause value for the trap
- mret_i  in  1  mret retiring this cycle
- mtvec_o  out  32  trap vector base (direct mode)
- mepc_o  out  32  mret return address
- mie_o  out  1  mstatus.MIE

## Operation
- Implemented CSRs: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, cycle/h 0xC00/0xC80, instret/h 0xC02/0xC82, mhartid 0xF14. All other addresses read 0 with illegal_o=1.
- mstatus: only MIE (bit 3) and MPIE (bit 7) stored; MPP [12:11] reads 2'b11; other bits read 0, writes ignored.
- misa reads 32'h4000_0100 constant; mhartid reads HART_ID; writes ignored.
- mtvec, mepc: bits [1:0] always written and read as 0.
- Read-only space addr[11:10]==2'b11: write ignored; illegal_o=1 when we_i and waddr_i in that space.
- Read port returns the register value before this cycle's update (no write-through bypass).
- Priority per cycle: trap_i > mret_i > we_i. With trap_i or mret_i high, the CSR write is dropped.
- Trap entry: mepc <= {trap_pc_i[31:2],2'b00}; mcause <= trap_cause_i; MPIE <= MIE; MIE <= 0.
- mret: MIE <= MPIE; MPIE <= 1.
- mcycle: 64-bit, +1 every cycle. Write to 0xB00 loads {hi, wdata_i}; write to 0xB80 loads {wdata_i, lo}; no increment in a write cycle.
- minstret: 64-bit, +1 when instret_i. Same half-write rule; write beats instret_i.
- Counters wrap 2^64-1 -> 0 silently; carry from low to high is within the same cycle.

## Timing
- All state updates on rising clk; reads and illegal_o combinational, zero latency.
- Written value visible on rdata_o the cycle after we_i.
- Reset (async, any time, including mid-trap): mstatus MIE=0, MPIE=0; mie, mscratch, mepc, mcause, mcycle, minstret = 0; mtvec = MTVEC_RESET & ~3. Outputs: mtvec_o = MTVEC_RESET & ~3, mepc_o = 0, mie_o = 0.
- First cycle after reset deassertion: mcycle increments to 1.

## Structure
- CSR address constants and mstatus bit indices go in the shared include.v as macros beside `CsrMemAddrWIDTH.
- One sub-module: csr_counter64 (64-bit counter, inc enable, lo/hi write enables, 32-bit write data, lo/hi outputs), instantiated twice.
- Read mux a single always@(*) case on raddr_i.

## Test plan
- Reset mid-run with mcycle=0x5 and MIE=1 -> immediately mcycle=0, mie_o=0, mtvec_o=MTVEC_RESET&~3.
- Write mscratch 0xDEADBEEF, then read 0x340 -> 0xDEADBEEF next cycle; same-cycle read still shows old value 0.
- Write mtvec 0x8000_0103 -> reads 0x8000_0100; write to 0xC00 -> ignored, illegal_o=1; read 0x7C0 -> 0, illegal_o=1.
- MIE=1, trap_i with trap_pc_i=0x0000_1236, cause 0xB, plus we_i to mscratch -> mepc=0x1234, mcause=0xB, MIE=0, MPIE=1, mscratch unchanged; then mret_i -> MIE=1, MPIE=1.
- Write mcycle low 0xFFFF_FFFF with high 0 -> next cycle reads lo 0xFFFF_FFFF, cycle after lo=0, hi=1.
- instret_i high same cycle as write 0x10 to 0xB02 -> minstret lo=0x10 (write wins); three more instret_i pulses -> 0x13; cycle alias 0xC02 matches.
